countdown_timer_ctrl: RTL and testbench

- Countdown-timer controller that sequences the 4-digit display driver.
- Owns the mm:ss count value, the user set/run/pause state machine and the blink request.
- Converts debounced button pulses and a 1 Hz tick into the `minutes`, `seconds` and `blink` inputs consumed by `display_driver`.
- Sits between the button debouncers / clock-enable divider and `display_driver` in the top level.

---
 rtl/countdown_timer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_ctrl
// Brief    : mm:ss countdown controller: set/run/pause/alarm FSM for display_driver.
// Revision : 1.0
// ============================================================================
module countdown_timer_ctrl #(
  parameter int MAX_VAL     = 59,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_1hz,
  input  logic       i_btn_start,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_blink,
  output logic       o_running,
  output logic       o_done
);

  localparam int                     c_alarm_w    = $clog2(ALARM_TICKS + 1);
  localparam logic [5:0]             c_max        = 6'(MAX_VAL);
  localparam logic [c_alarm_w-1:0]   c_alarm_last = c_alarm_w'(ALARM_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_MIN = 3'd1,
    S_SET_SEC = 3'd2,
    S_RUN     = 3'd3,
    S_PAUSE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               r_state;
  logic [5:0]           r_pre_min;
  logic [5:0]           r_pre_sec;
  logic [c_alarm_w-1:0] r_alarm_cnt;

  // Only the highest-priority button pulse in a cycle is allowed to act.
  logic w_start, w_mode, w_up, w_down;
  assign w_start = i_btn_start;
  assign w_mode  = i_btn_mode & ~i_btn_start;
  assign w_up    = i_btn_up   & ~i_btn_mode & ~i_btn_start;
  assign w_down  = i_btn_down & ~i_btn_up & ~i_btn_mode & ~i_btn_start;

  logic [5:0] w_min_inc, w_min_dec, w_sec_inc, w_sec_dec;
  assign w_min_inc = (o_minutes == c_max) ? 6'd0  : o_minutes + 6'd1;
  assign w_min_dec = (o_minutes == 6'd0)  ? c_max : o_minutes - 6'd1;
  assign w_sec_inc = (o_seconds == c_max) ? 6'd0  : o_seconds + 6'd1;
  assign w_sec_dec = (o_seconds == 6'd0)  ? c_max : o_seconds - 6'd1;

  // One-second countdown step; 00:00 holds (never reached in RUN).
  logic [5:0] w_run_min, w_run_sec;
  logic       w_tick_zero;
  logic       w_count_zero;
  assign w_count_zero = (o_minutes == 6'd0) && (o_seconds == 6'd0);
  assign w_run_sec    = (o_seconds != 6'd0) ? o_seconds - 6'd1 :
                        (o_minutes != 6'd0) ? c_max : 6'd0;
  assign w_run_min    = (o_seconds == 6'd0 && o_minutes != 6'd0) ? o_minutes - 6'd1 : o_minutes;
  assign w_tick_zero  = (o_minutes == 6'd0) && (o_seconds < 6'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      o_minutes   <= 6'd0;
      o_seconds   <= 6'd0;
      r_pre_min   <= 6'd0;
      r_pre_sec   <= 6'd0;
      r_alarm_cnt <= '0;
      o_blink     <= 1'b0;
      o_running   <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (!w_count_zero) begin
              r_state <= S_RUN;
              {o_blink, o_running, o_done} <= 3'b010;
            end
          end else if (w_mode) begin
            r_state <= S_SET_MIN;
            {o_blink, o_running, o_done} <= 3'b100;
          end
        end
        S_SET_MIN: begin
          if (w_start) begin
            r_state <= S_IDLE;
            {o_blink, o_running, o_done} <= 3'b000;
          end else if (w_mode) begin
            r_state <= S_SET_SEC;
            {o_blink, o_running, o_done} <= 3'b100;
          end else if (w_up) begin
            o_minutes <= w_min_inc;
            r_pre_min <= w_min_inc;
          end else if (w_down) begin
            o_minutes <= w_min_dec;
            r_pre_min <= w_min_dec;
          end
        end
        S_SET_SEC: begin
          if (w_start || w_mode) begin
            r_state <= S_IDLE;
            {o_blink, o_running, o_done} <= 3'b000;
          end else if (w_up) begin
            o_seconds <= w_sec_inc;
            r_pre_sec <= w_sec_inc;
          end else if (w_down) begin
            o_seconds <= w_sec_dec;
            r_pre_sec <= w_sec_dec;
          end
        end
        S_RUN: begin
          if (i_tick_1hz) begin
            o_minutes <= w_run_min;
            o_seconds <= w_run_sec;
          end
          // Reaching 00:00 beats a simultaneous pause request.
          if (i_tick_1hz && w_tick_zero) begin
            r_state     <= S_DONE;
            r_alarm_cnt <= '0;
            {o_blink, o_running, o_done} <= 3'b101;
          end else if (w_start) begin
            r_state <= S_PAUSE;
            {o_blink, o_running, o_done} <= 3'b000;
          end
        end
        S_PAUSE: begin
          if (w_start) begin
            r_state <= S_RUN;
            {o_blink, o_running, o_done} <= 3'b010;
          end else if (w_mode) begin
            r_state <= S_IDLE;
            {o_blink, o_running, o_done} <= 3'b000;
          end
        end
        S_DONE: begin
          if (w_start || w_mode || (i_tick_1hz && r_alarm_cnt == c_alarm_last)) begin
            r_state   <= S_IDLE;
            o_minutes <= r_pre_min;
            o_seconds <= r_pre_sec;
            {o_blink, o_running, o_done} <= 3'b000;
          end else if (i_tick_1hz) begin
            r_alarm_cnt <= r_alarm_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          {o_blink, o_running, o_done} <= 3'b000;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer_ctrl
// Brief    : Directed plus random stimulus against a seconds-based reference model.
// Revision : 1.0
// ============================================================================
module tb_countdown_timer_ctrl;

  localparam int MAXV  = 59;
  localparam int BASE  = MAXV + 1;
  localparam int ALARM = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, bstart = 1'b0, bmode = 1'b0, bup = 1'b0, bdown = 1'b0;
  logic [5:0] minutes, seconds;
  logic       blink, running, done;

  countdown_timer_ctrl #(.MAX_VAL(MAXV), .ALARM_TICKS(ALARM)) dut (
    .clk(clk), .rst_n(rst_n), .i_tick_1hz(tick),
    .i_btn_start(bstart), .i_btn_mode(bmode), .i_btn_up(bup), .i_btn_down(bdown),
    .o_minutes(minutes), .o_seconds(seconds),
    .o_blink(blink), .o_running(running), .o_done(done)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_SETM, M_SETS, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_st;
  int      m_min, m_sec, m_pmin, m_psec, m_alarm;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_outs();
    int b, r, d;
    b = (m_st == M_SETM || m_st == M_SETS || m_st == M_DONE) ? 1 : 0;
    r = (m_st == M_RUN) ? 1 : 0;
    d = (m_st == M_DONE) ? 1 : 0;
    return (m_min << 9) | (m_sec << 3) | (b << 2) | (r << 1) | d;
  endfunction

  function automatic int dut_outs();
    return (int'(minutes) << 9) | (int'(seconds) << 3) | (int'(blink) << 2) |
           (int'(running) << 1) | int'(done);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_min = 0; m_sec = 0; m_pmin = 0; m_psec = 0; m_alarm = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit mo, input bit u, input bit d);
    int total;
    if (s) begin mo = 0; u = 0; d = 0; end
    if (mo) begin u = 0; d = 0; end
    if (u) d = 0;
    case (m_st)
      M_IDLE:  if (s) begin if (m_min != 0 || m_sec != 0) m_st = M_RUN; end
               else if (mo) m_st = M_SETM;
      M_SETM:  if (s) m_st = M_IDLE; else if (mo) m_st = M_SETS;
               else if (u) begin m_min = (m_min + 1) % BASE; m_pmin = m_min; end
               else if (d) begin m_min = (m_min + BASE - 1) % BASE; m_pmin = m_min; end
      M_SETS:  if (s || mo) m_st = M_IDLE;
               else if (u) begin m_sec = (m_sec + 1) % BASE; m_psec = m_sec; end
               else if (d) begin m_sec = (m_sec + BASE - 1) % BASE; m_psec = m_sec; end
      M_RUN: begin
        if (t) begin
          total = m_min * BASE + m_sec;
          if (total > 0) total--;
          m_min = total / BASE;
          m_sec = total % BASE;
        end
        if (t && m_min == 0 && m_sec == 0) begin m_st = M_DONE; m_alarm = 0; end
        else if (s) m_st = M_PAUSE;
      end
      M_PAUSE: if (s) m_st = M_RUN; else if (mo) m_st = M_IDLE;
      M_DONE: begin
        if (s || mo) begin m_st = M_IDLE; m_min = m_pmin; m_sec = m_psec; end
        else if (t) begin
          m_alarm++;
          if (m_alarm == ALARM) begin m_st = M_IDLE; m_min = m_pmin; m_sec = m_psec; end
        end
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  // Inputs change at posedge+1; outputs are checked at the following posedge+1.
  task automatic cyc(input string tag, input bit t, input bit s, input bit mo, input bit u, input bit d);
    tick = t; bstart = s; bmode = mo; bup = u; bdown = d;
    model_step(t, s, mo, u, d);
    @(posedge clk); #1;
    tick = 0; bstart = 0; bmode = 0; bup = 0; bdown = 0;
    check(tag, dut_outs(), model_outs());
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("reset_async", dut_outs(), 0);
    @(posedge clk); #1;
    check("reset_hold", dut_outs(), model_outs());
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    cyc("idle", 0, 0, 0, 0, 0);

    cyc("mode_setmin", 0, 0, 1, 0, 0);
    cyc("down_wrap", 0, 0, 0, 0, 1);
    check("min_59", int'(minutes), 59);
    cyc("up_wrap", 0, 0, 0, 1, 0);
    check("min_0", int'(minutes), 0);
    cyc("up1", 0, 0, 0, 1, 0);
    cyc("up2", 0, 0, 0, 1, 0);
    check("min_2", int'(minutes), 2);
    cyc("mode_setsec", 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc("sec_up", 0, 0, 0, 1, 0);
    check("sec5_blink", {seconds, blink}, {6'd5, 1'b1});
    cyc("mode_idle", 0, 0, 1, 0, 0);
    check("idle_0205", dut_outs(), (2 << 9) | (5 << 3));

    cyc("start", 1'b0, 1, 0, 0, 0);
    ticks("run", 6);
    check("run_0159", {minutes, seconds}, {6'd1, 6'd59});
    ticks("run", 119);
    check("done_0000", dut_outs(), 3'b101);

    ticks("alarm", 10);
    check("alarm_exit", dut_outs(), (2 << 9) | (5 << 3));

    cyc("start2", 0, 1, 0, 0, 0);
    ticks("run2", 35);
    check("run_0130", {minutes, seconds}, {6'd1, 6'd30});
    cyc("tick_pause", 1, 1, 0, 0, 0);
    check("paused_0129", dut_outs(), (1 << 9) | (29 << 3));
    ticks("pause_ticks", 3);
    check("pause_frozen", dut_outs(), (1 << 9) | (29 << 3));
    cyc("resume", 0, 1, 0, 0, 0);
    check("resumed", int'(running), 1);
    ticks("run3", 89);
    check("done2", int'(done), 1);
    ticks("alarm2", 3);
    cyc("ack", 0, 1, 0, 0, 0);
    check("ack_exit", dut_outs(), (2 << 9) | (5 << 3));

    cyc("mode_pri", 0, 0, 1, 0, 0);
    cyc("up_down", 0, 0, 0, 1, 1);
    check("pri_up", int'(minutes), 3);
    cyc("to_idle", 0, 1, 0, 0, 0);
    cyc("start_mid", 0, 1, 0, 0, 0);
    ticks("run4", 4);
    do_reset();
    cyc("zero_start", 0, 1, 0, 0, 0);
    check("zero_guard", {running, minutes, seconds}, 13'd0);

    for (int i = 0; i < 4000; i++) begin
      cyc("rand", ($urandom_range(3) == 0), ($urandom_range(15) == 0), ($urandom_range(11) == 0),
          ($urandom_range(3) == 0), ($urandom_range(3) == 0));
      if (m_st == M_IDLE && $urandom_range(7) == 0)
        cyc("rand_run", 0, 1, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
